// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data memory: stores are queued and drained in program order.
// Define STORE_BUFFER_FWD_EN to let loads take data from buffered stores instead of stalling.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic [31:0] mem_Address_o,
  output logic [31:0] mem_WriteData_o,
  output logic        mem_MemRead_o,
  output logic        mem_MemWrite_o,
  input  logic [31:0] mem_data_i,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          is_load;
  logic          is_store;
  logic          is_full;
  logic          is_empty;
  logic          match_any;
  logic [PW-1:0] scan_idx;
  logic          enq;
  logic          deq;
`ifdef STORE_BUFFER_FWD_EN
  logic [31:0]   match_data;
`endif

  assign is_load  = MemRead_i;
  assign is_store = MemWrite_i & ~MemRead_i;
  assign is_full  = (count == CW'(DEPTH));
  assign is_empty = (count == '0);

  assign full_o  = ~rst_i & is_full;
  assign empty_o = rst_i | is_empty;

  // Scan oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    match_any = 1'b0;
    scan_idx  = '0;
`ifdef STORE_BUFFER_FWD_EN
    match_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PW'(i);
      if ((CW'(i) < count) && (addr_q[scan_idx] == Address_i[31:2])) begin
        match_any = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        match_data = data_q[scan_idx];
`endif
      end
    end
  end

  // Memory port arbitration: load first, then a drain forced by a full buffer, then an idle drain.
  always_comb begin
    data_o          = '0;
    stall_o         = 1'b0;
    mem_Address_o   = '0;
    mem_WriteData_o = '0;
    mem_MemRead_o   = 1'b0;
    mem_MemWrite_o  = 1'b0;
    enq             = 1'b0;
    deq             = 1'b0;
    if (!rst_i) begin
      if (is_load) begin
`ifdef STORE_BUFFER_FWD_EN
        mem_MemRead_o = 1'b1;
        mem_Address_o = Address_i;
        data_o        = match_any ? match_data : mem_data_i;
`else
        if (match_any) begin
          stall_o         = 1'b1;
          mem_MemWrite_o  = 1'b1;
          mem_Address_o   = {addr_q[head], 2'b00};
          mem_WriteData_o = data_q[head];
          deq             = 1'b1;
        end else begin
          mem_MemRead_o = 1'b1;
          mem_Address_o = Address_i;
          data_o        = mem_data_i;
        end
`endif
      end else if (is_store) begin
        if (is_full) begin
          stall_o         = 1'b1;
          mem_MemWrite_o  = 1'b1;
          mem_Address_o   = {addr_q[head], 2'b00};
          mem_WriteData_o = data_q[head];
          deq             = 1'b1;
        end else begin
          enq = 1'b1;
        end
      end else if (!is_empty) begin
        mem_MemWrite_o  = 1'b1;
        mem_Address_o   = {addr_q[head], 2'b00};
        mem_WriteData_o = data_q[head];
        deq             = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        addr_q[tail] <= Address_i[31:2];
        data_q[tail] <= WriteData_i;
        tail         <= tail + PW'(1);
      end
      if (deq) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(enq) - CW'(deq);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a table of single-cycle vectors plus hand-written
// sequences for same-address load behaviour, which differs with STORE_BUFFER_FWD_EN.
module tb_store_buffer;

  typedef struct {
    bit          rst;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          e_stall;
    bit          e_rd;
    bit          e_wr;
    logic [31:0] e_maddr;
    logic [31:0] e_mwd;
    logic [31:0] e_data;
    bit          e_full;
    bit          e_empty;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] Address_i;
  logic [31:0] WriteData_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic [31:0] mem_Address_o;
  logic [31:0] mem_WriteData_o;
  logic        mem_MemRead_o;
  logic        mem_MemWrite_o;
  logic [31:0] mem_data_i;
  logic        full_o;
  logic        empty_o;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  // Small data memory: unwritten words read back as 0xC0DE0000 | word index.
  logic [31:0] mem_model [64];
  bit   [63:0] written;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .MemRead_i      (MemRead_i),
    .MemWrite_i     (MemWrite_i),
    .Address_i      (Address_i),
    .WriteData_i    (WriteData_i),
    .data_o         (data_o),
    .stall_o        (stall_o),
    .mem_Address_o  (mem_Address_o),
    .mem_WriteData_o(mem_WriteData_o),
    .mem_MemRead_o  (mem_MemRead_o),
    .mem_MemWrite_o (mem_MemWrite_o),
    .mem_data_i     (mem_data_i),
    .full_o         (full_o),
    .empty_o        (empty_o)
  );

  always @(posedge clk) begin
    if (mem_MemWrite_o === 1'b1) begin
      mem_model[mem_Address_o[7:2]] <= mem_WriteData_o;
      written[mem_Address_o[7:2]]   <= 1'b1;
    end
  end

  assign mem_data_i = written[mem_Address_o[7:2]] ? mem_model[mem_Address_o[7:2]]
                                                   : (32'hC0DE0000 | {26'b0, mem_Address_o[7:2]});

  function automatic vec_t mk(bit rst, bit rd, bit wr, logic [31:0] addr, logic [31:0] wdata,
                              bit e_stall, bit e_rd, bit e_wr, logic [31:0] e_maddr,
                              logic [31:0] e_mwd, logic [31:0] e_data, bit e_full, bit e_empty,
                              string name);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.e_stall = e_stall; v.e_rd = e_rd; v.e_wr = e_wr; v.e_maddr = e_maddr;
    v.e_mwd = e_mwd; v.e_data = e_data; v.e_full = e_full; v.e_empty = e_empty;
    v.name = name;
    return v;
  endfunction

  task automatic chk(string tag, string field, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s got %h expected %h", tag, field, act, exp);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    @(negedge clk);
    rst_i       = v.rst;
    MemRead_i   = v.rd;
    MemWrite_i  = v.wr;
    Address_i   = v.addr;
    WriteData_i = v.wdata;
    #2;
  endtask

  task automatic checkOutput(vec_t v);
    chk(v.name, "stall",   {31'b0, stall_o},        {31'b0, v.e_stall});
    chk(v.name, "mem_rd",  {31'b0, mem_MemRead_o},  {31'b0, v.e_rd});
    chk(v.name, "mem_wr",  {31'b0, mem_MemWrite_o}, {31'b0, v.e_wr});
    chk(v.name, "full",    {31'b0, full_o},         {31'b0, v.e_full});
    chk(v.name, "empty",   {31'b0, empty_o},        {31'b0, v.e_empty});
    chk(v.name, "data",    data_o,                  v.e_data);
    if (v.e_rd || v.e_wr) chk(v.name, "mem_addr", mem_Address_o, v.e_maddr);
    if (v.e_wr)           chk(v.name, "mem_wdata", mem_WriteData_o, v.e_mwd);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int stalls;
    vec_t v;
    rst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0; Address_i = '0; WriteData_i = '0;

    //        rst rd wr addr          wdata          stl rd wr maddr         mwd           data          ful emp
    vecs.push_back(mk(1, 0, 1, 32'h10, 32'h11111111, 0, 0, 0, 32'h0,  32'h0,         32'h0,         0, 1, "reset_gate"));
    vecs.push_back(mk(0, 0, 1, 32'h10, 32'h11111111, 0, 0, 0, 32'h0,  32'h0,         32'h0,         0, 1, "st_10"));
    vecs.push_back(mk(0, 0, 0, 32'h0,  32'h0,        0, 0, 1, 32'h10, 32'h11111111,  32'h0,         0, 0, "idle_drain_10"));
    vecs.push_back(mk(0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  32'h0,         32'h0,         0, 1, "idle_empty"));
    vecs.push_back(mk(0, 0, 1, 32'h0,  32'hA0,       0, 0, 0, 32'h0,  32'h0,         32'h0,         0, 1, "st_0"));
    vecs.push_back(mk(0, 0, 1, 32'h4,  32'hA4,       0, 0, 0, 32'h0,  32'h0,         32'h0,         0, 0, "st_4"));
    vecs.push_back(mk(0, 0, 1, 32'h8,  32'hA8,       0, 0, 0, 32'h0,  32'h0,         32'h0,         0, 0, "st_8"));
    vecs.push_back(mk(0, 0, 1, 32'hC,  32'hAC,       0, 0, 0, 32'h0,  32'h0,         32'h0,         0, 0, "st_c"));
    vecs.push_back(mk(0, 0, 1, 32'h14, 32'hB4,       1, 0, 1, 32'h0,  32'hA0,        32'h0,         1, 0, "st_14_full"));
    vecs.push_back(mk(0, 0, 1, 32'h14, 32'hB4,       0, 0, 0, 32'h0,  32'h0,         32'h0,         0, 0, "st_14_retry"));
    vecs.push_back(mk(0, 0, 0, 32'h0,  32'h0,        0, 0, 1, 32'h4,  32'hA4,        32'h0,         1, 0, "drain_4"));
    vecs.push_back(mk(0, 0, 0, 32'h0,  32'h0,        0, 0, 1, 32'h8,  32'hA8,        32'h0,         0, 0, "drain_8"));
    vecs.push_back(mk(0, 1, 0, 32'h20, 32'h0,        0, 1, 0, 32'h20, 32'h0,         32'hC0DE0008,  0, 0, "ld_20_nomatch"));
    vecs.push_back(mk(0, 0, 0, 32'h0,  32'h0,        0, 0, 1, 32'hC,  32'hAC,        32'h0,         0, 0, "drain_c"));
    vecs.push_back(mk(0, 0, 0, 32'h0,  32'h0,        0, 0, 1, 32'h14, 32'hB4,        32'h0,         0, 0, "drain_14"));
    vecs.push_back(mk(0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  32'h0,         32'h0,         0, 1, "idle_empty2"));
    vecs.push_back(mk(0, 1, 0, 32'h4,  32'h0,        0, 1, 0, 32'h4,  32'h0,         32'hA4,        0, 1, "ld_4_mem"));
    vecs.push_back(mk(0, 0, 1, 32'h30, 32'hD0,       0, 0, 0, 32'h0,  32'h0,         32'h0,         0, 1, "st_30"));
    vecs.push_back(mk(0, 0, 1, 32'h34, 32'hD1,       0, 0, 0, 32'h0,  32'h0,         32'h0,         0, 0, "st_34"));
    vecs.push_back(mk(0, 0, 1, 32'h38, 32'hD2,       0, 0, 0, 32'h0,  32'h0,         32'h0,         0, 0, "st_38"));
    vecs.push_back(mk(1, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  32'h0,         32'h0,         0, 1, "rst_in_drain"));
    vecs.push_back(mk(0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  32'h0,         32'h0,         0, 1, "post_rst_idle"));
    vecs.push_back(mk(0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  32'h0,         32'h0,         0, 1, "post_rst_idle2"));
    vecs.push_back(mk(0, 1, 0, 32'h30, 32'h0,        0, 1, 0, 32'h30, 32'h0,         32'hC0DE000C,  0, 1, "ld_30_untouched"));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Same-address load after two buffered stores: youngest data must be returned.
    v = mk(0, 0, 1, 32'h8, 32'hAAAA0000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, "fw_st_a");
    applyStimulus(v); checkOutput(v);
    v = mk(0, 0, 1, 32'h8, 32'hBBBB0000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, "fw_st_b");
    applyStimulus(v); checkOutput(v);
`ifdef STORE_BUFFER_FWD_EN
    v = mk(0, 1, 0, 32'h8, 32'h0, 0, 1, 0, 32'h8, 32'h0, 32'hBBBB0000, 0, 0, "fw_ld_8");
    applyStimulus(v); checkOutput(v);
    v = mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 32'h8, 32'hAAAA0000, 32'h0, 0, 0, "fw_drain_a");
    applyStimulus(v); checkOutput(v);
    v = mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 32'h8, 32'hBBBB0000, 32'h0, 0, 0, "fw_drain_b");
    applyStimulus(v); checkOutput(v);
`else
    v = mk(0, 1, 0, 32'h8, 32'h0, 0, 1, 0, 32'h8, 32'h0, 32'hBBBB0000, 0, 1, "nofw_ld_8");
    stalls = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(v);
      if (stall_o !== 1'b1) break;
      chk("nofw_stall", "mem_rd",    {31'b0, mem_MemRead_o},  32'h0);
      chk("nofw_stall", "mem_wr",    {31'b0, mem_MemWrite_o}, 32'h1);
      chk("nofw_stall", "mem_addr",  mem_Address_o,           32'h8);
      chk("nofw_stall", "mem_wdata", mem_WriteData_o,
          (c == 0) ? 32'hAAAA0000 : 32'hBBBB0000);
      stalls++;
    end
    chk("nofw_ld_8", "stall_cycles", stalls, 32'd2);
    checkOutput(v);
`endif
    v = mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, "fw_final_empty");
    applyStimulus(v); checkOutput(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, 4, number of buffered store entries (power of two, 2..16).
REQ-002 Port: clk_i  input  1  clock; all state updates on rising edge.
REQ-003 Port: rst_i  input  1  synchronous, active-high reset.
REQ-004 Port: MemRead_i  input  1  load request from the MEM stage.
REQ-005 Port: MemWrite_i  input  1  store request from the MEM stage.
REQ-006 Port: Address_i  input  32  byte address; word-aligned, bits [1:0] ignored.
REQ-007 Port: WriteData_i  input  32  store data.
REQ-008 Port: data_o  output  32  load result to the MEM/WB stage.
REQ-009 Port: stall_o  output  1  request is not accepted this cycle; the pipeline holds its inputs.
REQ-010 Port: mem_Address_o  output  32  address to the data memory.
REQ-011 Port: mem_WriteData_o  output  32  write data to the data memory.
REQ-012 Port: mem_MemRead_o / mem_MemWrite_o  output  1 each  data memory read and write strobes.
REQ-013 Port: mem_data_i  input  32  read data from the data memory, valid in the same cycle.
REQ-014 Port: full_o / empty_o  output  1 each  buffer status.

Function
REQ-015 Buffer: circular FIFO of DEPTH {word address[31:2], data} entries, with head/tail pointers and a count; pointers wrap modulo DEPTH.
REQ-016 Request decode: MemRead_i=1 means load, regardless of MemWrite_i. MemWrite_i=1 with MemRead_i=0 means store. Both 0 means idle.
REQ-017 Port arbitration per cycle, highest priority first:
  - load: drive Address_i onto the memory port with mem_MemRead_o=1;
  - full-stall drain;
  - idle drain.
  The memory is driven by only one of these per cycle.
REQ-018 Load: data_o comes from mem_data_i, or from a forwarded entry per REQ-022; no added latency.
REQ-019 Store with count<DEPTH: enqueue at tail on the clock edge; stall_o=0; the memory port is not used by the store.
REQ-020 Store with count==DEPTH:
  - stall_o=1;
  - the head entry drains in that cycle (mem_MemWrite_o=1, head address and data);
  - the store enqueues on the following cycle.
REQ-021 Idle with count>0: drain the head entry, dequeue on the edge.
  - Idle with count==0: all mem strobes are 0.
  - Mem outputs are combinational from state and inputs.
REQ-022 Load address match: compare Address_i[31:2] against all valid entries.
  - On one or more matches, return the youngest matching entry's data on data_o.
  - mem_MemRead_o stays 1; mem_data_i is discarded.
REQ-023 Same-cycle dequeue and enqueue (the REQ-020 follow-up store while another drain happens) leaves count unchanged.
REQ-024 Entries are written to memory in strict program order; there is no coalescing.
REQ-025 full_o = (count==DEPTH); empty_o = (count==0); both are registered-state derived.
REQ-026 When neither a load nor a forward occurs, data_o = 0.

Reset
REQ-027 rst_i=1 at a clock edge:
  - head, tail and count go to 0;
  - buffered entries are discarded, including a store being drained that cycle;
  - entry storage need not be cleared.
REQ-028 While rst_i=1:
  - stall_o=0, mem_MemRead_o=0, mem_MemWrite_o=0;
  - data_o=0, full_o=0, empty_o=1.

Configuration
REQ-029 Macro STORE_BUFFER_FWD_EN defined: the load forwarding of REQ-022 is compiled in.
REQ-030 Macro STORE_BUFFER_FWD_EN undefined: a load that matches any entry behaves as follows:
  - asserts stall_o and does not issue mem_MemRead_o;
  - the head entry drains each cycle;
  - the load issues normally once no entry matches.

Verification
REQ-031 Store 0x11111111@0x10, then idle one cycle -> mem_MemWrite_o=1, mem_Address_o=0x10, mem_WriteData_o=0x11111111; then empty_o=1.
REQ-032 Four stores to 0x0, 0x4, 0x8, 0xC with no idle cycles -> full_o=1. A fifth store to 0x14 -> stall_o=1 for exactly one cycle, with 0x0 drained that cycle. The store to 0x14 enqueues next, and count stays 4.
REQ-033 With STORE_BUFFER_FWD_EN: store 0xAAAA0000@0x8, store 0xBBBB0000@0x8, load 0x8 back-to-back -> data_o=0xBBBB0000 in the load cycle, stall_o=0.
REQ-034 Without STORE_BUFFER_FWD_EN: the same sequence -> load stalls 2 cycles while both entries drain, then data_o=mem_data_i=0xBBBB0000.
REQ-035 Load 0x20 (no match) while count=2 -> mem_MemRead_o=1, data_o=mem_data_i, no drain that cycle, count unchanged.
REQ-036 Three buffered stores, rst_i=1 for one cycle during a drain -> empty_o=1 after the edge; no further mem_MemWrite_o pulses.
